dmem_io_arbiter: RTL and testbench
==================================

// Module: dmem_io_arbiter
// PURPOSE
//  Sequences every CPU data-side access (load/store, IO read/write) onto the data memory or the IO devices.
//  Shares the data-memory write port between the CPU and the UART program loader (upg).
//  Inserts stall cycles for the synchronous data-memory read latency.
//  Sits between the controller/ALU/register file and the data memory, LED and switch blocks.
// PARAMETERS
//  RD_LAT      1             data-memory read latency in cycles, legal 1..4
//  IO_BASE     32'hFFFFFC00  IO window base; is_io = (cpu_addr[31:10] == IO_BASE[31:10])
//  LED_OFFSET  10'h060       LED register offset within the IO window
//  SW_OFFSET   10'h070       switch register offset within the IO window
// PORTS
//  clock        in   1   system clock; all state changes on the rising edge
//  reset        in   1   synchronous, active-high
//  cpu_mread    in   1   memory read request
//  cpu_mwrite   in   4   byte-lane write enables; nonzero = store
//  cpu_ioread   in   1   IO read request
//  cpu_iowrite  in   1   IO write request
//  cpu_addr     in   32  byte address (ALU result)
//  cpu_wdata    in   32  store data from the register file
//  cpu_rdata    out  32  load data to the register file
//  cpu_stall    out  1   hold the PC and pipeline while high
//  upg_active   in   1   UART loader owns the memory
//  upg_wen      in   1   loader word-write strobe
//  upg_addr     in   14  loader word address
//  upg_wdata    in   32  loader write data
//  upg_ack      out  1   one-cycle pulse, the cycle after a committed loader write
//  dmem_we      out  4   data-memory byte write enables
//  dmem_addr    out  32  data-memory byte address
//  dmem_wdata   out  32  data-memory write data
//  dmem_rdata   in   32  data-memory read data, valid RD_LAT cycles after the address
//  io_rdata     in   24  switch read data
//  io_wdata     out  32  IO write data
//  io_we        out  1   IO write strobe
//  led_cs       out  1   LED chip select, active high
//  sw_cs        out  1   switch chip select, active high
//  bus_err      out  1   sticky protocol-error flag
// BEHAVIOUR
//  FSM states: IDLE, RD_WAIT, RD_DONE, UPG. Reset -> IDLE.
//  Reset values: cnt=0, rdata_q=0, upg_ack=0, bus_err=0.
//  While reset is high, every output is 0.
//  IDLE:
//   - upg_active=1 -> UPG. Loader has priority over a same-cycle CPU request; the CPU request is not issued.
//   - else cpu_mread=1 -> cpu_stall=1 combinationally, dmem_addr=cpu_addr, cnt<=RD_LAT-1, go to RD_WAIT.
//   - else cpu_mwrite!=0 -> dmem_we=cpu_mwrite, dmem_addr=cpu_addr, dmem_wdata=cpu_wdata.
//     Single cycle, no stall.
//   - IO accesses are combinational with no stall:
//     led_cs = is_io & (cpu_ioread|cpu_iowrite) & addr[9:0]==LED_OFFSET; sw_cs likewise for SW_OFFSET.
//     io_we=cpu_iowrite, io_wdata=cpu_wdata, cpu_rdata={8'b0,io_rdata} when cpu_ioread.
//  RD_WAIT: cpu_stall=1, dmem_addr=cpu_addr (the CPU holds it). If cnt==0: rdata_q<=dmem_rdata, go to RD_DONE.
//   Otherwise cnt<=cnt-1.
//  RD_DONE: cpu_stall=0, cpu_rdata=rdata_q. No new request is accepted. Next state is IDLE.
//  Total load cost: RD_LAT+1 stall cycles, then 1 data cycle.
//  UPG: cpu_stall=1.
//   - upg_wen=1 -> dmem_we=4'hF, dmem_addr={16'b0,upg_addr,2'b00}, dmem_wdata=upg_wdata; upg_ack<=1 next cycle.
//   - CPU requests are ignored.
//   - upg_active=0 -> IDLE. The stall drops in IDLE unless a new CPU load stalls it.
//  upg_active rising during RD_WAIT or RD_DONE: the read completes first, then IDLE -> UPG.
//  bus_err<=1 when any of these occurs; cleared only by reset:
//   - cpu_mread and a nonzero cpu_mwrite together
//   - a memory request and an IO request together
//   - an IO request with !is_io
//   - a memory request with is_io
//  bus_err conflict priority: mread > mwrite > IO. Only the highest-priority request is executed.
//  Outside its own cycle, each output is 0: dmem_we, io_we, led_cs, sw_cs, cpu_rdata.
// TESTING
//  T1 RD_LAT=1: store 0x10, 0xDEADBEEF, mwrite=F -> dmem_we=F for 1 cycle, stall=0.
//     Then load 0x10 -> stall high 2 cycles, cpu_rdata=0xDEADBEEF in the 3rd cycle.
//  T2 ioread at 0xFFFFFC70, io_rdata=0xABCDEF -> sw_cs=1, cpu_rdata=0x00ABCDEF same cycle, stall=0.
//  T3 iowrite at 0xFFFFFC60, wdata 0x1234 -> led_cs=1, io_we=1, io_wdata=0x1234, dmem_we=0.
//  T4 upg_active=1, upg_wen, addr 0x5, data 0xCAFEF00D -> dmem_we=F, dmem_addr=0x14, upg_ack 1 cycle later, stall=1.
//  T5 mread+ioread together at 0x20 -> bus_err=1 and stays 1; the memory read completes normally.
//  T6 reset in RD_WAIT (RD_LAT=4) -> next cycle IDLE, stall=0, cpu_rdata=0, bus_err=0.

Source files
------------

// File: rtl/dmem_io_arbiter.sv
// Routes CPU loads/stores and IO accesses to data memory or LED/switch regs; UART loader owns the memory while active.
// Stores and IO: zero latency. Loads: RD_LAT+1 stall cycles, then one data cycle. The loader stalls the CPU throughout.
module dmem_io_arbiter #(
    parameter int unsigned RD_LAT     = 1,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FC00,
    parameter logic [9:0]  LED_OFFSET = 10'h060,
    parameter logic [9:0]  SW_OFFSET  = 10'h070
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_mread,
    input  logic [3:0]  cpu_mwrite,
    input  logic        cpu_ioread,
    input  logic        cpu_iowrite,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        upg_active,
    input  logic        upg_wen,
    input  logic [13:0] upg_addr,
    input  logic [31:0] upg_wdata,
    output logic        upg_ack,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic [23:0] io_rdata,
    output logic [31:0] io_wdata,
    output logic        io_we,
    output logic        led_cs,
    output logic        sw_cs,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2,
        UPG     = 2'd3
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [31:0] rdata_q, rdata_nxt;
    logic        upg_ack_q, upg_ack_nxt;
    logic        bus_err_q, bus_err_nxt;

    logic is_io, mem_rd, mem_wr, mem_req, io_req, proto_err;

    assign is_io   = (cpu_addr[31:10] == IO_BASE[31:10]);
    assign mem_rd  = cpu_mread;
    assign mem_wr  = |cpu_mwrite;
    assign mem_req = mem_rd | mem_wr;
    assign io_req  = cpu_ioread | cpu_iowrite;

    assign proto_err = (mem_rd & mem_wr) | (mem_req & io_req) |
                       (io_req & ~is_io) | (mem_req & is_io);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            rdata_q   <= 32'd0;
            upg_ack_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rdata_q   <= rdata_nxt;
            upg_ack_q <= upg_ack_nxt;
            bus_err_q <= bus_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        rdata_nxt   = rdata_q;
        upg_ack_nxt = 1'b0;
        bus_err_nxt = bus_err_q;

        cpu_rdata  = 32'd0;
        cpu_stall  = 1'b0;
        dmem_we    = 4'd0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        io_wdata   = 32'd0;
        io_we      = 1'b0;
        led_cs     = 1'b0;
        sw_cs      = 1'b0;
        upg_ack    = upg_ack_q;
        bus_err    = bus_err_q;

        case (state)
            IDLE: begin
                if (upg_active) begin
                    // Loader wins; hold the CPU so its pending request is replayed later.
                    cpu_stall = 1'b1;
                    state_nxt = UPG;
                end else begin
                    if (proto_err) bus_err_nxt = 1'b1;
                    if (mem_rd) begin
                        cpu_stall = 1'b1;
                        dmem_addr = cpu_addr;
                        cnt_nxt   = CNT_INIT;
                        state_nxt = RD_WAIT;
                    end else if (mem_wr) begin
                        dmem_we    = cpu_mwrite;
                        dmem_addr  = cpu_addr;
                        dmem_wdata = cpu_wdata;
                    end else if (io_req) begin
                        led_cs = is_io & (cpu_addr[9:0] == LED_OFFSET);
                        sw_cs  = is_io & (cpu_addr[9:0] == SW_OFFSET);
                        io_we  = cpu_iowrite;
                        if (cpu_iowrite) io_wdata = cpu_wdata;
                        if (cpu_ioread)  cpu_rdata = {8'b0, io_rdata};
                    end
                end
            end
            RD_WAIT: begin
                cpu_stall = 1'b1;
                dmem_addr = cpu_addr;
                if (cnt == 2'd0) begin
                    rdata_nxt = dmem_rdata;
                    state_nxt = RD_DONE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            RD_DONE: begin
                cpu_rdata = rdata_q;
                state_nxt = IDLE;
            end
            UPG: begin
                cpu_stall = 1'b1;
                if (upg_wen) begin
                    dmem_we     = 4'hF;
                    dmem_addr   = {16'b0, upg_addr, 2'b00};
                    dmem_wdata  = upg_wdata;
                    upg_ack_nxt = 1'b1;
                end
                if (!upg_active) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are forced quiet for the whole reset cycle, including the registered flags.
        if (reset) begin
            cpu_rdata  = 32'd0;
            cpu_stall  = 1'b0;
            dmem_we    = 4'd0;
            dmem_addr  = 32'd0;
            dmem_wdata = 32'd0;
            io_wdata   = 32'd0;
            io_we      = 1'b0;
            led_cs     = 1'b0;
            sw_cs      = 1'b0;
            upg_ack    = 1'b0;
            bus_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_io_arbiter.sv
// Two arbiters (RD_LAT=1 and RD_LAT=4) on shared stimulus, each with its own reset and memory model.
module tb_dmem_io_arbiter;

    logic        clock = 1'b0;
    logic        rst1, rst4, sel;
    logic        cpu_mread, cpu_ioread, cpu_iowrite, upg_active, upg_wen;
    logic [3:0]  cpu_mwrite;
    logic [31:0] cpu_addr, cpu_wdata, upg_wdata;
    logic [13:0] upg_addr;
    logic [23:0] io_rdata;

    logic [31:0] rdata1, daddr1, dwdata1, iowd1, drd1;
    logic [3:0]  we1;
    logic        stall1, ack1, iowe1, led1, sw1, err1;
    logic [31:0] rdata4, daddr4, dwdata4, iowd4, drd4;
    logic [3:0]  we4;
    logic        stall4, ack4, iowe4, led4, sw4, err4;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] shadow [0:255];
    logic [31:0] sb [$];

    always #5 clock = ~clock;

    dmem_io_arbiter #(.RD_LAT(1)) u_dut1 (
        .clock(clock), .reset(rst1), .cpu_mread(cpu_mread), .cpu_mwrite(cpu_mwrite),
        .cpu_ioread(cpu_ioread), .cpu_iowrite(cpu_iowrite), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(rdata1), .cpu_stall(stall1),
        .upg_active(upg_active), .upg_wen(upg_wen), .upg_addr(upg_addr),
        .upg_wdata(upg_wdata), .upg_ack(ack1), .dmem_we(we1), .dmem_addr(daddr1),
        .dmem_wdata(dwdata1), .dmem_rdata(drd1), .io_rdata(io_rdata),
        .io_wdata(iowd1), .io_we(iowe1), .led_cs(led1), .sw_cs(sw1), .bus_err(err1)
    );

    dmem_io_arbiter #(.RD_LAT(4)) u_dut4 (
        .clock(clock), .reset(rst4), .cpu_mread(cpu_mread), .cpu_mwrite(cpu_mwrite),
        .cpu_ioread(cpu_ioread), .cpu_iowrite(cpu_iowrite), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(rdata4), .cpu_stall(stall4),
        .upg_active(upg_active), .upg_wen(upg_wen), .upg_addr(upg_addr),
        .upg_wdata(upg_wdata), .upg_ack(ack4), .dmem_we(we4), .dmem_addr(daddr4),
        .dmem_wdata(dwdata4), .dmem_rdata(drd4), .io_rdata(io_rdata),
        .io_wdata(iowd4), .io_we(iowe4), .led_cs(led4), .sw_cs(sw4), .bus_err(err4)
    );

    // Synchronous data memories: one-deep and four-deep read pipelines.
    logic [31:0] mem1 [0:255];
    logic [31:0] mem4 [0:255];
    logic [31:0] p1;
    logic [31:0] p4 [0:3];

    always @(posedge clock) begin
        p1 <= mem1[daddr1[9:2]];
        for (int b = 0; b < 4; b++)
            if (we1[b]) mem1[daddr1[9:2]][8*b +: 8] <= dwdata1[8*b +: 8];
    end
    assign drd1 = p1;

    always @(posedge clock) begin
        p4[0] <= mem4[daddr4[9:2]];
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
        for (int b = 0; b < 4; b++)
            if (we4[b]) mem4[daddr4[9:2]][8*b +: 8] <= dwdata4[8*b +: 8];
    end
    assign drd4 = p4[3];

    logic [31:0] s_rdata, s_daddr, s_dwdata, s_iowd;
    logic [3:0]  s_we;
    logic        s_stall, s_ack, s_iowe, s_led, s_sw, s_err;
    assign s_rdata  = sel ? rdata4  : rdata1;
    assign s_daddr  = sel ? daddr4  : daddr1;
    assign s_dwdata = sel ? dwdata4 : dwdata1;
    assign s_iowd   = sel ? iowd4   : iowd1;
    assign s_we     = sel ? we4     : we1;
    assign s_stall  = sel ? stall4  : stall1;
    assign s_ack    = sel ? ack4    : ack1;
    assign s_iowe   = sel ? iowe4   : iowe1;
    assign s_led    = sel ? led4    : led1;
    assign s_sw     = sel ? sw4     : sw1;
    assign s_err    = sel ? err4    : err1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input string tag);
        cpu_mwrite = m;
        cpu_addr   = a;
        cpu_wdata  = d;
        for (int b = 0; b < 4; b++)
            if (m[b]) shadow[a[9:2]][8*b +: 8] = d[8*b +: 8];
        @(negedge clock);
        check_val({tag, "_we"},    {28'b0, s_we}, {28'b0, m});
        check_val({tag, "_addr"},  s_daddr, a);
        check_val({tag, "_wdat"},  s_dwdata, d);
        check_val({tag, "_stall"}, {31'b0, s_stall}, 32'd0);
        step();
        cpu_mwrite = 4'd0;
    endtask

    task automatic do_load(input logic [31:0] a, input int exp_stalls, input string tag);
        int n;
        logic [31:0] e;
        sb.push_back(shadow[a[9:2]]);
        cpu_mread = 1'b1;
        cpu_addr  = a;
        n = 0;
        @(negedge clock);
        while (s_stall && n < 40) begin
            n++;
            @(negedge clock);
        end
        e = sb.pop_front();
        check_val({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
        check_val({tag, "_rdata"},  s_rdata, e);
        step();
        cpu_mread  = 1'b0;
        cpu_ioread = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        cpu_mread = 0; cpu_mwrite = 0; cpu_ioread = 0; cpu_iowrite = 0;
        cpu_addr = 0; cpu_wdata = 0; upg_active = 0; upg_wen = 0;
        upg_addr = 0; upg_wdata = 0; io_rdata = 0;
        sel = 0; rst1 = 1; rst4 = 1;
        step();

        // Outputs stay quiet under reset even with a store presented.
        cpu_mwrite = 4'hF; cpu_addr = 32'h10; cpu_wdata = 32'h1;
        @(negedge clock);
        check_val("rst_we",    {28'b0, s_we}, 32'd0);
        check_val("rst_stall", {31'b0, s_stall}, 32'd0);
        check_val("rst_err",   {31'b0, s_err}, 32'd0);
        check_val("rst_ack",   {31'b0, s_ack}, 32'd0);
        step();
        cpu_mwrite = 0; rst1 = 0;
        @(negedge clock);
        check_val("idle_stall", {31'b0, s_stall}, 32'd0);
        check_val("idle_rdata", s_rdata, 32'd0);
        step();

        // T1: store, load, partial-lane store, reload
        do_store(32'h10, 32'hDEADBEEF, 4'hF, "t1_st");
        @(negedge clock);
        check_val("t1_we_off", {28'b0, s_we}, 32'd0);
        step();
        do_load(32'h10, 2, "t1_ld");
        @(negedge clock);
        check_val("t1_rdata_off", s_rdata, 32'd0);
        step();
        do_store(32'h10, 32'h11112222, 4'h3, "t1_bst");
        do_load(32'h10, 2, "t1_bld");

        // T2: switch read
        cpu_ioread = 1; cpu_addr = 32'hFFFFFC70; io_rdata = 24'hABCDEF;
        @(negedge clock);
        check_val("t2_sw",    {31'b0, s_sw}, 32'd1);
        check_val("t2_led",   {31'b0, s_led}, 32'd0);
        check_val("t2_rdata", s_rdata, 32'h00ABCDEF);
        check_val("t2_stall", {31'b0, s_stall}, 32'd0);
        step();
        cpu_ioread = 0;

        // T3: LED write
        cpu_iowrite = 1; cpu_addr = 32'hFFFFFC60; cpu_wdata = 32'h1234;
        @(negedge clock);
        check_val("t3_led",   {31'b0, s_led}, 32'd1);
        check_val("t3_sw",    {31'b0, s_sw}, 32'd0);
        check_val("t3_iowe",  {31'b0, s_iowe}, 32'd1);
        check_val("t3_iowd",  s_iowd, 32'h1234);
        check_val("t3_we",    {28'b0, s_we}, 32'd0);
        check_val("t3_rdata", s_rdata, 32'd0);
        step();
        cpu_iowrite = 0;
        @(negedge clock);
        check_val("t3_err", {31'b0, s_err}, 32'd0);
        step();

        // T4: loader write; a same-cycle CPU store must be dropped
        do_store(32'h40, 32'h77777777, 4'hF, "t4_pre");
        upg_active = 1; cpu_mwrite = 4'hF; cpu_addr = 32'h40; cpu_wdata = 32'h99;
        @(negedge clock);
        check_val("t4_prio_we", {28'b0, s_we}, 32'd0);
        check_val("t4_prio_stall", {31'b0, s_stall}, 32'd1);
        step();
        upg_wen = 1; upg_addr = 14'h5; upg_wdata = 32'hCAFEF00D;
        shadow[5] = 32'hCAFEF00D;
        @(negedge clock);
        check_val("t4_we",    {28'b0, s_we}, 32'hF);
        check_val("t4_addr",  s_daddr, 32'h14);
        check_val("t4_wdat",  s_dwdata, 32'hCAFEF00D);
        check_val("t4_stall", {31'b0, s_stall}, 32'd1);
        check_val("t4_ack0",  {31'b0, s_ack}, 32'd0);
        step();
        upg_wen = 0;
        @(negedge clock);
        check_val("t4_ack1",   {31'b0, s_ack}, 32'd1);
        check_val("t4_we_off", {28'b0, s_we}, 32'd0);
        step();
        upg_active = 0;
        @(negedge clock);
        check_val("t4_ack_off", {31'b0, s_ack}, 32'd0);
        check_val("t4_stall2",  {31'b0, s_stall}, 32'd1);
        step();
        cpu_mwrite = 0;
        @(negedge clock);
        check_val("t4_idle_stall", {31'b0, s_stall}, 32'd0);
        step();
        do_load(32'h14, 2, "t4_ld");
        do_load(32'h40, 2, "t4_blk");

        // T5: load with a simultaneous IO read sets the sticky error; the load still completes
        do_store(32'h20, 32'h5A5A1234, 4'hF, "t5_st");
        cpu_ioread = 1; io_rdata = 24'h123456;
        do_load(32'h20, 2, "t5_ld");
        @(negedge clock);
        check_val("t5_err", {31'b0, s_err}, 32'd1);
        step(); step(); step();
        @(negedge clock);
        check_val("t5_err_sticky", {31'b0, s_err}, 32'd1);
        step();

        // T6: switch to the RD_LAT=4 instance
        rst1 = 1; sel = 1; rst4 = 0;
        @(negedge clock);
        check_val("t6_idle_stall", {31'b0, s_stall}, 32'd0);
        check_val("t6_idle_err",   {31'b0, s_err}, 32'd0);
        step();
        cpu_iowrite = 1; cpu_addr = 32'h100; cpu_wdata = 32'h55;
        @(negedge clock);
        check_val("t6_oow_led", {31'b0, s_led}, 32'd0);
        step();
        cpu_iowrite = 0;
        @(negedge clock);
        check_val("t6_oow_err", {31'b0, s_err}, 32'd1);
        step();
        do_store(32'h30, 32'h0BADCAFE, 4'hF, "t6_st");
        do_load(32'h30, 5, "t6_ld");

        cpu_mread = 1; cpu_addr = 32'h30;
        step(); step();
        rst4 = 1;
        @(negedge clock);
        check_val("t6_rst_stall", {31'b0, s_stall}, 32'd0);
        check_val("t6_rst_err",   {31'b0, s_err}, 32'd0);
        step();
        rst4 = 0; cpu_mread = 0;
        @(negedge clock);
        check_val("t6_post_stall", {31'b0, s_stall}, 32'd0);
        check_val("t6_post_rdata", s_rdata, 32'd0);
        check_val("t6_post_err",   {31'b0, s_err}, 32'd0);
        step();
        do_load(32'h30, 5, "t6_rld");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
